mipi_csi_rx_packet_controller: RTL and testbench

- Packet-level sequencer sitting beside the CSI-2 RX packet decoder, the ECC block and the CRC block.
- Consumes the ECC-corrected packet header and classifies each packet as short (sync/generic) or long (pixel data).
- Drives the decoder's payload length, tracks frame/line state and counters, checks the CRC result, and raises sticky error flags for the register file.

---
 rtl/mipi_csi_rx_packet_controller.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mipi_csi_rx_packet_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_rx_packet_controller.sv
// CSI-2 RX packet sequencer: classifies ECC-corrected headers, drives payload length, tracks frame/line state.
// Optional payload/CRC watchdog is enabled by defining CSI_RX_PKT_TIMEOUT_EN.
module mipi_csi_rx_packet_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             transmission_active_i,
  input  logic             header_valid_i,
  input  logic [7:0]       data_id_i,
  input  logic [15:0]      word_count_i,
  input  logic             ecc_uncorrectable_i,
  input  logic             crc_received_valid_i,
  input  logic             crc_match_i,
  input  logic             err_clear_i,
  output logic [15:0]      payload_length_o,
  output logic [1:0]       vc_o,
  output logic [5:0]       data_type_o,
  output logic             long_packet_o,
  output logic             frame_active_o,
  output logic             line_active_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             line_start_o,
  output logic             line_end_o,
  output logic             packet_done_o,
  output logic [CNT_W-1:0] frame_count_o,
  output logic [CNT_W-1:0] line_count_o,
  output logic             err_ecc_o,
  output logic             err_crc_o,
  output logic             err_sync_o,
  output logic             err_timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CRC_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t           state_q, state_d;
  logic [1:0]       vc_q, vc_d;
  logic [5:0]       dt_q, dt_d;
  logic [15:0]      len_q, len_d;
  logic             long_q, long_d;
  logic             frame_act_q, frame_act_d;
  logic             line_act_q, line_act_d;
  logic             fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             err_ecc_q, err_ecc_d;
  logic             err_crc_q, err_crc_d;
  logic             err_sync_q, err_sync_d;
  logic             set_ecc, set_crc, set_sync;
  logic             hdr_fire;
  logic             hdr_long;
  logic             timeout_hit;

  assign hdr_fire = (state_q == S_HDR) && transmission_active_i && header_valid_i;
  assign hdr_long = (data_id_i[5:0] >= DT_LONG_MIN);

  always_comb begin
    state_d     = state_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    len_d       = len_q;
    long_d      = long_q;
    frame_act_d = frame_act_q;
    line_act_d  = line_act_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    done_d      = 1'b0;
    set_ecc     = 1'b0;
    set_crc     = 1'b0;
    set_sync    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (transmission_active_i) state_d = S_HDR;
      end

      S_HDR: begin
        if (!transmission_active_i) begin
          state_d = S_IDLE;
        end else if (header_valid_i) begin
          vc_d = data_id_i[7:6];
          dt_d = data_id_i[5:0];
          if (ecc_uncorrectable_i) begin
            set_ecc = 1'b1;
            len_d   = '0;
            state_d = S_DRAIN;
          end else if (hdr_long) begin
            len_d    = word_count_i;
            long_d   = 1'b1;
            set_sync = !frame_act_q;
            state_d  = S_PAYLOAD;
          end else begin
            len_d   = '0;
            done_d  = 1'b1;
            state_d = S_DRAIN;
            case (data_id_i[5:0])
              DT_FS: begin
                set_sync    = frame_act_q;
                frame_act_d = 1'b1;
                fs_d        = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                line_cnt_d  = '0;
              end
              DT_FE: begin
                line_act_d = 1'b0;
                if (!frame_act_q) begin
                  set_sync = 1'b1;
                end else begin
                  frame_act_d = 1'b0;
                  fe_d        = 1'b1;
                end
              end
              DT_LS: begin
                line_act_d = 1'b1;
                ls_d       = 1'b1;
              end
              DT_LE: begin
                line_act_d = 1'b0;
                le_d       = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      S_PAYLOAD: begin
        // Lanes going quiet before the CRC means the packet was cut short.
        if (!transmission_active_i) begin
          set_crc = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_CRC_WAIT;
        end
      end

      S_CRC_WAIT: begin
        if (crc_received_valid_i) begin
          if (crc_match_i) begin
            done_d = 1'b1;
            if (frame_act_q) line_cnt_d = line_cnt_q + 1'b1;
          end else begin
            set_crc = 1'b1;
          end
          state_d = S_DRAIN;
        end else if (!transmission_active_i) begin
          set_crc = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!transmission_active_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) long_d = 1'b0;

    // A new error event wins over a clear in the same cycle.
    err_ecc_d  = set_ecc  | (err_ecc_q  & ~err_clear_i);
    err_crc_d  = set_crc  | (err_crc_q  & ~err_clear_i);
    err_sync_d = set_sync | (err_sync_q & ~err_clear_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      vc_q        <= '0;
      dt_q        <= '0;
      len_q       <= '0;
      long_q      <= 1'b0;
      frame_act_q <= 1'b0;
      line_act_q  <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
      err_ecc_q   <= 1'b0;
      err_crc_q   <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      len_q       <= len_d;
      long_q      <= long_d;
      frame_act_q <= frame_act_d;
      line_act_q  <= line_act_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_ecc_q   <= err_ecc_d;
      err_crc_q   <= err_crc_d;
      err_sync_q  <= err_sync_d;
    end
  end

`ifdef CSI_RX_PKT_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_to_q, err_to_d;
  logic            in_body_q, in_body_d;
  logic            set_to;

  assign in_body_q   = (state_q == S_PAYLOAD) || (state_q == S_CRC_WAIT);
  assign in_body_d   = (state_d == S_PAYLOAD) || (state_d == S_CRC_WAIT);
  assign timeout_hit = in_body_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  // Only flag the watchdog when it actually caused the abort.
  assign set_to      = timeout_hit && (state_d == S_DRAIN) &&
                       !((state_q == S_CRC_WAIT) && crc_received_valid_i);

  always_comb begin
    to_cnt_d = (in_body_q && in_body_d) ? to_cnt_q + 1'b1 : '0;
    err_to_d = set_to | (err_to_q & ~err_clear_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout_o = err_to_q;
`else
  assign timeout_hit   = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  // The decoder starts counting payload in the header-done cycle, so the length bypasses the flop.
  assign payload_length_o = hdr_fire ? len_d : len_q;
  assign vc_o             = vc_q;
  assign data_type_o      = dt_q;
  assign long_packet_o    = long_q;
  assign frame_active_o   = frame_act_q;
  assign line_active_o    = line_act_q;
  assign frame_start_o    = fs_q;
  assign frame_end_o      = fe_q;
  assign line_start_o     = ls_q;
  assign line_end_o       = le_q;
  assign packet_done_o    = done_q;
  assign frame_count_o    = frame_cnt_q;
  assign line_count_o     = line_cnt_q;
  assign err_ecc_o        = err_ecc_q;
  assign err_crc_o        = err_crc_q;
  assign err_sync_o       = err_sync_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_controller.sv
// Bench for mipi_csi_rx_packet_controller: directed plan followed by random packets against a packet-level model.
module tb_mipi_csi_rx_packet_controller;
  localparam int CNT_W = 4;

  logic             clk_i;
  logic             reset_n_i;
  logic             transmission_active_i;
  logic             header_valid_i;
  logic [7:0]       data_id_i;
  logic [15:0]      word_count_i;
  logic             ecc_uncorrectable_i;
  logic             crc_received_valid_i;
  logic             crc_match_i;
  logic             err_clear_i;
  logic [15:0]      payload_length_o;
  logic [1:0]       vc_o;
  logic [5:0]       data_type_o;
  logic             long_packet_o;
  logic             frame_active_o;
  logic             line_active_o;
  logic             frame_start_o;
  logic             frame_end_o;
  logic             line_start_o;
  logic             line_end_o;
  logic             packet_done_o;
  logic [CNT_W-1:0] frame_count_o;
  logic [CNT_W-1:0] line_count_o;
  logic             err_ecc_o;
  logic             err_crc_o;
  logic             err_sync_o;
  logic             err_timeout_o;

  mipi_csi_rx_packet_controller #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .transmission_active_i(transmission_active_i), .header_valid_i(header_valid_i),
    .data_id_i(data_id_i), .word_count_i(word_count_i),
    .ecc_uncorrectable_i(ecc_uncorrectable_i), .crc_received_valid_i(crc_received_valid_i),
    .crc_match_i(crc_match_i), .err_clear_i(err_clear_i),
    .payload_length_o(payload_length_o), .vc_o(vc_o), .data_type_o(data_type_o),
    .long_packet_o(long_packet_o), .frame_active_o(frame_active_o), .line_active_o(line_active_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o), .line_start_o(line_start_o),
    .line_end_o(line_end_o), .packet_done_o(packet_done_o),
    .frame_count_o(frame_count_o), .line_count_o(line_count_o),
    .err_ecc_o(err_ecc_o), .err_crc_o(err_crc_o), .err_sync_o(err_sync_o),
    .err_timeout_o(err_timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Packet-level reference state.
  logic             m_fa, m_la;
  logic [CNT_W-1:0] m_fc, m_lc;
  logic             m_ecc, m_crc, m_sync, m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " counts"}, 32'({frame_count_o, line_count_o}), 32'({m_fc, m_lc}));
    chk({tag, " flags"},
        32'({frame_active_o, line_active_o, err_ecc_o, err_crc_o, err_sync_o, err_timeout_o}),
        32'({m_fa, m_la, m_ecc, m_crc, m_sync, m_to}));
  endtask

  task automatic clear_errors();
    err_clear_i = 1'b1;
    step();
    err_clear_i = 1'b0;
    m_ecc = 0; m_crc = 0; m_sync = 0; m_to = 0;
    chk_status("clear");
  endtask

  // Short packet, or any header carrying an uncorrectable ECC error.
  task automatic short_pkt(input logic [5:0] dt, input bit ecc_err, input bit clr);
    logic [1:0]  vc;
    logic [15:0] wc;
    logic [3:0]  exp_p;
    vc = 2'($urandom);
    wc = 16'($urandom);
    transmission_active_i = 1'b1;
    step();
    if ($urandom_range(0, 1) == 1) step();
    header_valid_i      = 1'b1;
    data_id_i           = {vc, dt};
    word_count_i        = wc;
    ecc_uncorrectable_i = ecc_err;
    err_clear_i         = clr;
    #1;
    chk("short plen comb", 32'(payload_length_o), 32'd0);
    if (clr) begin
      m_ecc = 0; m_crc = 0; m_sync = 0; m_to = 0;
    end
    exp_p = 4'b0000;
    if (ecc_err) begin
      m_ecc = 1;
    end else begin
      case (dt)
        6'h00: begin if (m_fa) m_sync = 1; m_fa = 1; exp_p[3] = 1; m_fc = m_fc + 1'b1; m_lc = '0; end
        6'h01: begin m_la = 0; if (!m_fa) m_sync = 1; else begin m_fa = 0; exp_p[2] = 1; end end
        6'h02: begin m_la = 1; exp_p[1] = 1; end
        6'h03: begin m_la = 0; exp_p[0] = 1; end
        default: ;
      endcase
    end
    step();
    header_valid_i      = 1'b0;
    ecc_uncorrectable_i = 1'b0;
    err_clear_i         = 1'b0;
    chk("short pulses",
        32'({frame_start_o, frame_end_o, line_start_o, line_end_o, packet_done_o}),
        32'({exp_p, !ecc_err}));
    chk("short id", 32'({vc_o, data_type_o, long_packet_o, payload_length_o}),
        32'({vc, dt, 1'b0, 16'd0}));
    chk_status("short");
    transmission_active_i = 1'b0;
    step();
    chk("pulses one cycle",
        32'({frame_start_o, frame_end_o, line_start_o, line_end_o, packet_done_o}), 32'd0);
    step();
  endtask

  // mode 0: good CRC, 1: bad CRC, 2: lanes drop after dly cycles in CRC_WAIT.
  task automatic long_pkt(input logic [5:0] dt, input logic [15:0] wc, input int mode, input int dly);
    logic [1:0] vc;
    vc = 2'($urandom);
    transmission_active_i = 1'b1;
    step();
    if ($urandom_range(0, 1) == 1) step();
    header_valid_i = 1'b1;
    data_id_i      = {vc, dt};
    word_count_i   = wc;
    #1;
    chk("long plen comb", 32'(payload_length_o), 32'(wc));
    if (!m_fa) m_sync = 1;
    step();
    header_valid_i = 1'b0;
    chk("long hdr", 32'({vc_o, data_type_o, long_packet_o, payload_length_o}), 32'({vc, dt, 1'b1, wc}));
    step();
    repeat (dly) step();
    if (mode == 2) begin
      transmission_active_i = 1'b0;
      step();
      m_crc = 1;
      chk("trunc idle", 32'({long_packet_o, packet_done_o}), 32'd0);
      chk_status("trunc");
    end else begin
      crc_received_valid_i = 1'b1;
      crc_match_i          = (mode == 0);
      step();
      crc_received_valid_i = 1'b0;
      crc_match_i          = 1'b0;
      if (mode == 0 && m_fa) m_lc = m_lc + 1'b1;
      if (mode == 1) m_crc = 1;
      chk("long done", 32'({packet_done_o, long_packet_o}), 32'({mode == 0, 1'b1}));
      chk_status("long");
      transmission_active_i = 1'b0;
      step();
      chk("long idle", 32'({long_packet_o, packet_done_o}), 32'd0);
    end
    step();
  endtask

  initial begin
    reset_n_i = 1'b0;
    transmission_active_i = 0; header_valid_i = 0; data_id_i = '0; word_count_i = '0;
    ecc_uncorrectable_i = 0; crc_received_valid_i = 0; crc_match_i = 0; err_clear_i = 0;
    m_fa = 0; m_la = 0; m_fc = '0; m_lc = '0; m_ecc = 0; m_crc = 0; m_sync = 0; m_to = 0;
    repeat (3) step();
    chk("reset outputs",
        32'({payload_length_o, vc_o, data_type_o, long_packet_o, frame_start_o, frame_end_o,
             line_start_o, line_end_o, packet_done_o}), 32'd0);
    chk_status("reset");
    reset_n_i = 1'b1;
    step();

    // Nominal frame: FS, LS, long good, LE, FE.
    short_pkt(6'h00, 0, 0);
    short_pkt(6'h02, 0, 0);
    long_pkt(6'h2A, 16'd8, 0, 1);
    short_pkt(6'h03, 0, 0);
    short_pkt(6'h01, 0, 0);
    chk("nominal counts", 32'({frame_count_o, line_count_o}), 32'({4'd1, 4'd1}));

    // Bad CRC inside a frame, then clear.
    short_pkt(6'h00, 0, 0);
    long_pkt(6'h2B, 16'd16, 1, 2);
    clear_errors();

    // Uncorrectable header while a clear is asserted: set wins.
    short_pkt(6'h12, 1, 1);
    chk("ecc sticky", 32'(err_ecc_o), 32'd1);
    clear_errors();

    // Second FS without FE.
    short_pkt(6'h00, 0, 0);
    chk("double fs sync", 32'(err_sync_o), 32'd1);
    clear_errors();

    // Truncated payload (WC=100, lanes drop 10 cycles in), then a normal packet.
    long_pkt(6'h24, 16'd100, 2, 9);
    long_pkt(6'h24, 16'd0, 0, 0);
    clear_errors();

    // Missing CRC: watchdog aborts, or the FSM keeps waiting when it is absent.
    transmission_active_i = 1'b1;
    step();
    header_valid_i = 1'b1; data_id_i = 8'h2A; word_count_i = 16'd8;
    step();
    header_valid_i = 1'b0;
`ifdef CSI_RX_PKT_TIMEOUT_EN
    repeat (15) step();
    chk("timeout early", 32'(err_timeout_o), 32'd0);
    step();
    m_to = 1;
    chk("timeout hit", 32'(err_timeout_o), 32'd1);
    transmission_active_i = 1'b0;
    step();
    step();
`else
    repeat (20) step();
    chk("no timeout wait", 32'({err_timeout_o, long_packet_o}), 32'({1'b0, 1'b1}));
    crc_received_valid_i = 1'b1; crc_match_i = 1'b1;
    step();
    crc_received_valid_i = 1'b0; crc_match_i = 1'b0;
    if (m_fa) m_lc = m_lc + 1'b1;
    transmission_active_i = 1'b0;
    step();
    step();
`endif
    chk_status("watchdog");
    clear_errors();

    // Frame counter wrap.
    repeat ((1 << CNT_W) + 1) short_pkt(6'h00, 0, 0);
    chk("frame wrap", 32'(frame_count_o), 32'(m_fc));
    clear_errors();

    // Random packet mix.
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [15:0] wc;
      r  = $urandom_range(0, 10);
      wc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      case (r)
        0:       short_pkt(6'h00, 0, 0);
        1:       short_pkt(6'h01, 0, 0);
        2:       short_pkt(6'h02, 0, 0);
        3:       short_pkt(6'h03, 0, 0);
        4:       short_pkt(6'($urandom_range(4, 15)), 0, 0);
        5:       short_pkt(6'($urandom), 1, 0);
        9:       long_pkt(6'($urandom_range(16, 63)), wc, 1, $urandom_range(0, 3));
        10:      long_pkt(6'($urandom_range(16, 63)), wc, 2, $urandom_range(0, 3));
        default: long_pkt(6'($urandom_range(16, 63)), wc, 0, $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 7) == 0) clear_errors();
    end
    chk_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
